// File: rtl/time_display_pkg.sv
// Shared definitions for the time_display block.
//   - 7-segment digit table (active-low, bit7 = dp, bits6..0 = g..a),
//     dash and blank patterns
//   - conversion FSM state enumeration
//   - digit slot indices and field limits
//   - slot_seg(): turns a stored digit code into a segment pattern
package time_display_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV_S,
    CONV_M,
    CONV_H,
    COMMIT
  } conv_state_t;

  localparam logic [7:0] SEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit slot indices; an[i] enables slot i.
  localparam logic [2:0] IDX_SEC_ONES  = 3'd0;
  localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
  localparam logic [2:0] IDX_MIN_ONES  = 3'd2;
  localparam logic [2:0] IDX_MIN_TENS  = 3'd3;
  localparam logic [2:0] IDX_HOUR_ONES = 3'd4;
  localparam logic [2:0] IDX_HOUR_TENS = 3'd5;
  localparam logic [2:0] IDX_LAST      = IDX_HOUR_TENS;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  // Stored digit code for an out-of-range field.
  localparam logic [3:0] CODE_DASH = 4'd10;

  // Digits get the decimal point when dp is set; the dash never does.
  function automatic logic [7:0] slot_seg(input logic [3:0] code, input logic dp);
    if (code > 4'd9) return SEG_DASH;
    return SEG_TABLE[code] & {~dp, 7'h7F};
  endfunction

endpackage

// File: rtl/time_display_scan_tick.sv
// scan_tick: free-running divider producing a one-cycle tick every
// SCAN_DIV clk cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset (counter to 0)
//   tick : high for the one cycle in which the counter sits at SCAN_DIV-1
module scan_tick #(
  parameter int SCAN_DIV = 200000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/time_display.sv
// time_display: six-digit multiplexed HH.MM.SS driver for a common-anode
// 7-segment display.
//   clk, rst            : clock, synchronous active-high reset
//   hour/minute/second  : binary time, snapshotted once per full scan
//   seg[7:0]            : active-low segments (bit7 = dp)
//   an[7:0]             : active-low digit enables, an[7:6] held high
// The binary fields are converted to BCD by repeated subtract-10 in a small
// FSM; results only reach the display registers in COMMIT.
// Optional feature: define TIME_DISPLAY_BLANK_EN to blank a leading zero in
// the hour-tens slot.
module time_display
  import time_display_pkg::*;
#(
  parameter int SCAN_DIV = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  output logic [7:0] seg,
  output logic [7:0] an
);

  logic tick;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---------------- scan index ----------------
  logic [2:0] idx, idx_nxt;
  logic       wrap;

  // NOTE: combinational blocks assign every output a default first so no
  // path through the block can leave a latch behind.
  always_comb begin
    idx_nxt = idx;
    if (tick) idx_nxt = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
  end

  assign wrap = tick && (idx == IDX_LAST);

  // ---------------- conversion ----------------
  conv_state_t state, next_state;
  logic [5:0]  snap_h, snap_m, snap_s;
  logic [5:0]  rem;
  logic [3:0]  tens;
  logic [3:0]  pend [6];
  logic [3:0]  disp [6];

  logic [5:0]  field_snap, field_lim, next_val;
  logic [2:0]  field_base;
  logic        field_bad;

  // Which field the current CONV_x state works on, and what comes next.
  always_comb begin
    field_snap = snap_s;
    field_lim  = MS_MAX;
    field_base = IDX_SEC_ONES;
    next_val   = snap_m;
    next_state = CONV_M;
    case (state)
      CONV_M: begin
        field_snap = snap_m;
        field_base = IDX_MIN_ONES;
        next_val   = snap_h;
        next_state = CONV_H;
      end
      CONV_H: begin
        field_snap = snap_h;
        field_lim  = HOUR_MAX;
        field_base = IDX_HOUR_ONES;
        next_val   = '0;
        next_state = COMMIT;
      end
      default: ;
    endcase
  end

  assign field_bad = (field_snap > field_lim);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      snap_h <= '0;
      snap_m <= '0;
      snap_s <= '0;
      rem    <= '0;
      tens   <= '0;
      // NOTE: these six-entry arrays are plain flops, not RAM, so clearing
      // them in reset is cheap and guarantees a defined "00.00.00" display.
      for (int i = 0; i < 6; i++) begin
        pend[i] <= '0;
        disp[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wrap) begin
            snap_h <= hour;
            snap_m <= minute;
            snap_s <= second;
            rem    <= second;
            tens   <= '0;
            state  <= CONV_S;
          end
        end
        CONV_S, CONV_M, CONV_H: begin
          if (rem >= 6'd10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 4'd1;
          end else begin
            pend[field_base]        <= field_bad ? CODE_DASH : rem[3:0];
            pend[field_base + 3'd1] <= field_bad ? CODE_DASH : tens;
            rem   <= next_val;
            tens  <= '0;
            state <= next_state;
          end
        end
        COMMIT: begin
          // All six digits move together so a half-converted time never shows.
          disp  <= pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- output registers ----------------
  // an and seg are both derived from idx_nxt in the same cycle, so they
  // always refer to the same slot.
  logic [3:0] slot_code;
  logic [7:0] seg_nxt;

  always_comb begin
    slot_code = disp[idx_nxt];
    seg_nxt   = slot_seg(slot_code,
                         (idx_nxt == IDX_MIN_ONES) || (idx_nxt == IDX_HOUR_ONES));
`ifdef TIME_DISPLAY_BLANK_EN
    if ((idx_nxt == IDX_HOUR_TENS) && (slot_code == 4'd0)) seg_nxt = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      an  <= 8'hFE;
      seg <= SEG_TABLE[0];
    end else begin
      idx <= idx_nxt;
      an  <= ~(8'd1 << idx_nxt);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display with SCAN_DIV = 32.
// The reference model works from edge counts: the slot shown after edge n is
// (n / D) % 6, snapshots happen on every edge that is a multiple of 6*D, and a
// snapshot becomes visible after sum(field/10 + 1) + 1 edges plus one more
// edge for the output register.
module tb_time_display;

  localparam int D     = 32;
  localparam int FRAME = 6 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] hour = '0, minute = '0, second = '0;
  logic [7:0] seg, an;

  time_display #(.SCAN_DIV(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .hour   (hour),
    .minute (minute),
    .second (second),
    .seg    (seg),
    .an     (an)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  localparam logic [7:0] PAT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int         n = 0;
  int         sh [3];          // shown values: 0 sec, 1 min, 2 hour
  int         pd [3];
  int         pd_commit;
  bit         pd_valid  = 1'b0;
  bit         model_live = 1'b0;
  logic [7:0] exp_an, exp_seg;

  function automatic logic [7:0] exp_slot(input int k);
    int v, lim, d;
    logic [7:0] p;
    v   = sh[k / 2];
    lim = (k / 2 == 2) ? 23 : 59;
    if (v > lim) return 8'hBF;
    d = (k % 2 == 0) ? v % 10 : v / 10;
`ifdef TIME_DISPLAY_BLANK_EN
    if (k == 5 && d == 0) return 8'hFF;
`endif
    p = PAT[d];
    if (k == 2 || k == 4) p[7] = 1'b0;
    return p;
  endfunction

  always @(posedge clk) begin
    int idx;
    if (rst) begin
      n = 0;
      sh = '{0, 0, 0};
      pd_valid = 1'b0;
      model_live = 1'b1;
    end else begin
      n++;
      if (pd_valid && pd_commit == n - 1) begin
        sh = pd;
        pd_valid = 1'b0;
      end
      if (n % FRAME == 0 && !pd_valid) begin
        pd = '{int'(second), int'(minute), int'(hour)};
        pd_commit = n + (int'(second) / 10 + 1) + (int'(minute) / 10 + 1)
                      + (int'(hour) / 10 + 1) + 1;
        pd_valid = 1'b1;
      end
    end
    idx     = (n / D) % 6;
    exp_an  = ~(8'd1 << idx);
    exp_seg = exp_slot(idx);
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("an_cycle", an, exp_an);
      check("seg_cycle", seg, exp_seg);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_time(input int h, input int m, input int s);
    hour = 6'(h); minute = 6'(m); second = 6'(s);
  endtask

  task automatic expect_slot(input string name, input int k, input logic [7:0] want);
    bit found = 1'b0;
    for (int i = 0; i < 8 * D && !found; i++) begin
      @(negedge clk);
      if (an === ~(8'd1 << k)) found = 1'b1;
    end
    if (found) check(name, seg, want);
    else       check({name, "_found"}, {7'd0, found}, 8'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit snapped;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_an", an, 8'hFE);
    check("reset_seg", seg, 8'hC0);
    rst = 1'b0;

    // 13:07:59
    set_time(13, 7, 59);
    repeat (FRAME + 30) @(negedge clk);
    expect_slot("h13_slot4", 4, 8'h30);
    expect_slot("h13_slot5", 5, 8'hF9);
    expect_slot("s59_slot0", 0, 8'h90);
    expect_slot("s59_slot1", 1, 8'h92);

    // minute out of range
    set_time(5, 60, 0);
    repeat (2 * FRAME) @(negedge clk);
    expect_slot("m60_slot2", 2, 8'hBF);
    expect_slot("m60_slot3", 3, 8'hBF);
    expect_slot("m60_slot4", 4, 8'h12);

    // hour tens zero: blank or zero
    set_time(7, 30, 15);
    repeat (2 * FRAME) @(negedge clk);
`ifdef TIME_DISPLAY_BLANK_EN
    expect_slot("h07_slot5", 5, 8'hFF);
`else
    expect_slot("h07_slot5", 5, 8'hC0);
`endif

    // reset pulse in the middle of a conversion
    set_time(12, 34, 56);
    repeat (2 * FRAME) @(negedge clk);
    snapped = 1'b0;
    for (int i = 0; i < 2 * FRAME && !snapped; i++) begin
      @(negedge clk);
      if (n > 0 && n % FRAME == 0) snapped = 1'b1;
    end
    check("snapshot_seen", {7'd0, snapped}, 8'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midconv_rst_an", an, 8'hFE);
    check("midconv_rst_seg", seg, 8'hC0);
    rst = 1'b0;
    set_time(21, 45, 8);
    repeat (FRAME + 30) @(negedge clk);
    expect_slot("post_rst_slot0", 0, 8'h80);
    expect_slot("post_rst_slot1", 1, 8'hC0);

    // inputs change every cycle, including out-of-range values
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      set_time($urandom_range(63), $urandom_range(63), $urandom_range(63));
    end

    // held random values, mostly in range
    for (int f = 0; f < 8; f++) begin
      set_time($urandom_range(25), $urandom_range(61), $urandom_range(61));
      repeat (FRAME + 40) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
